alu_issue_arbiter: RTL and testbench

Round-robin issue arbiter that shares the single 8-lane ALU between the operand-collector (OC) entries. Each cycle it grants at most one ready collector entry. It suppresses issue when the CDB write slot in the ALU's result cycle is already claimed. It can also block a warp from issuing further ALU work while one of its branches is unresolved. It sits between the OC entries and the ALU input register and drives the ALU's valid and the collector-side dequeue.

---
 rtl/alu_issue_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Round-robin issue arbiter sharing the single ALU between operand-collector
// entries. Grants at most one entry per cycle, holds back non-branch issue
// when the CDB slot of the ALU result cycle is already claimed, and (when the
// ALU_ARB_BR_BLOCK_EN macro is defined) blocks a warp from issuing while one
// of its branches is unresolved. With the macro undefined the branch-pending
// state is removed and BrPending_ARB is tied to zero.
module alu_issue_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_WARPS = 8,
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   Req_OC_ARB,
  input  logic [3*NUM_REQ-1:0] WarpID_OC_ARB,
  input  logic [NUM_REQ-1:0]   IsBr_OC_ARB,
  input  logic                 CDB_Claim_Next,
  input  logic                 BrDone_SIMT_ARB,
  input  logic [2:0]           BrDone_WarpID_SIMT_ARB,
  output logic [NUM_REQ-1:0]   Grant_ARB_OC,
  output logic [SW-1:0]        Sel_ARB_OC,
  output logic                 Valid_ARB_ALU,
  output logic [NUM_WARPS-1:0] BrPending_ARB,
  output logic [15:0]          IssueCnt_ARB
);

  logic [SW-1:0]      ptr_q, ptr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0] blocked_s;
  logic [NUM_REQ-1:0] cand_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [SW-1:0]      sel_s;
  logic               found_s;
  logic               valid_s;
  logic [2:0]         sel_warp_s;

`ifdef ALU_ARB_BR_BLOCK_EN
  logic [NUM_WARPS-1:0] br_pend_q, br_pend_d;

  // A request is blocked while its warp has an outstanding branch.
  always_comb begin
    blocked_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      blocked_s[i] = br_pend_q[WarpID_OC_ARB[3*i +: 3]];
    end
  end

  // Branch-pending update: BrDone clears, a granted branch sets its warp.
  always_comb begin
    br_pend_d = br_pend_q;
    if (BrDone_SIMT_ARB) begin
      br_pend_d[BrDone_WarpID_SIMT_ARB] = 1'b0;
    end else begin
      br_pend_d = br_pend_d;
    end
    if (valid_s && IsBr_OC_ARB[sel_s]) begin
      br_pend_d[sel_warp_s] = 1'b1;
    end else begin
      br_pend_d = br_pend_d;
    end
  end

  // Branch-pending flags register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_pend_q <= '0;
    end else begin
      br_pend_q <= br_pend_d;
    end
  end

  assign BrPending_ARB = br_pend_q;
`else
  // Without blocking, branch completion and warp IDs have no effect here.
  logic unused_br_s;
  assign unused_br_s   = ^{BrDone_SIMT_ARB, BrDone_WarpID_SIMT_ARB, WarpID_OC_ARB, sel_warp_s};
  assign blocked_s     = '0;
  assign BrPending_ARB = '0;
`endif

  assign sel_warp_s = WarpID_OC_ARB[3*sel_s +: 3];

  // Candidates: requesting, not blocked, and not a CDB writer when the slot is taken.
  always_comb begin
    cand_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s[i] = Req_OC_ARB[i] & ~blocked_s[i] & ~(CDB_Claim_Next & ~IsBr_OC_ARB[i]);
    end
  end

  // Round-robin search starting at ptr_q; first candidate found wins.
  always_comb begin
    logic [SW-1:0] idx_v;
    found_s = 1'b0;
    sel_s   = '0;
    idx_v   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = ptr_q + SW'(k);
      if (!found_s && cand_s[idx_v]) begin
        found_s = 1'b1;
        sel_s   = idx_v;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant outputs are forced idle while reset is asserted.
  always_comb begin
    grant_s = '0;
    valid_s = found_s & rst;
    if (valid_s) begin
      grant_s[sel_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign Grant_ARB_OC  = grant_s;
  assign Sel_ARB_OC    = valid_s ? sel_s : '0;
  assign Valid_ARB_ALU = valid_s;

  // Pointer advances past the granted entry; issue counter counts grants.
  always_comb begin
    if (valid_s) begin
      ptr_d = sel_s + SW'(1);
      cnt_d = cnt_q + 16'd1;
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Pointer and issue counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= 16'd0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign IssueCnt_ARB = cnt_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed testbench for alu_issue_arbiter (default NUM_REQ=4, NUM_WARPS=8).
// Works with or without ALU_ARB_BR_BLOCK_EN defined.
module tb_alu_issue_arbiter;

`ifdef ALU_ARB_BR_BLOCK_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] wid;
  logic [3:0]  isbr;
  logic        claim;
  logic        brd;
  logic [2:0]  brd_w;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        valid;
  logic [7:0]  brp;
  logic [15:0] cnt;

  int vectors = 0;
  int errors  = 0;
  logic [15:0] exp_cnt = 16'd0;

  localparam logic [11:0] WID0 = {3'd3, 3'd2, 3'd1, 3'd0};

  always #5 clk = ~clk;

  alu_issue_arbiter dut (
    .clk                    (clk),
    .rst                    (rst),
    .Req_OC_ARB             (req),
    .WarpID_OC_ARB          (wid),
    .IsBr_OC_ARB            (isbr),
    .CDB_Claim_Next         (claim),
    .BrDone_SIMT_ARB        (brd),
    .BrDone_WarpID_SIMT_ARB (brd_w),
    .Grant_ARB_OC           (grant),
    .Sel_ARB_OC             (sel),
    .Valid_ARB_ALU          (valid),
    .BrPending_ARB          (brp),
    .IssueCnt_ARB           (cnt)
  );

  // Advance one clock edge; count the issue if one is expected this cycle.
  task automatic step(input logic [3:0] eg);
    if (eg != 4'b0000) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'hF; wid = WID0; isbr = 4'h0; claim = 1'b0; brd = 1'b0; brd_w = 3'd0;
    #2;
    vectors++; if (grant !== 4'h0) begin errors++; $display("FAIL reset_grant got %h exp 0", grant); end
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    vectors++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
    vectors++; if (brp !== 8'h00) begin errors++; $display("FAIL reset_brp got %h exp 00", brp); end
    vectors++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    @(negedge clk);
    rst = 1'b1; req = 4'h0;
    #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    req = 4'hF; wid = WID0; isbr = 4'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      eg = 4'(1 << (k % 4));
      vectors++; if (grant !== eg) begin errors++; $display("FAIL rr_grant[%0d] got %h exp %h", k, grant, eg); end
      vectors++; if (sel !== 2'(k % 4)) begin errors++; $display("FAIL rr_sel[%0d] got %0d exp %0d", k, sel, k % 4); end
      vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b exp 1", k, valid); end
      step(eg);
    end
    req = 4'h0;
    #1;
    vectors++; if (grant !== 4'h0 || valid !== 1'b0 || sel !== 2'd0) begin errors++; $display("FAIL rr_idle got g=%h v=%b s=%0d exp 0/0/0", grant, valid, sel); end
    vectors++; if (cnt !== 16'd5) begin errors++; $display("FAIL rr_cnt got %0d exp 5", cnt); end
  endtask

  task automatic test_wrap_ptr();
    // Ptr is 1: grant entry 1 to move it to 2.
    req = 4'b0010; #1;
    vectors++; if (grant !== 4'b0010) begin errors++; $display("FAIL wrap_setup got %h exp 2", grant); end
    step(4'b0010);
    req = 4'b1001; #1;
    vectors++; if (grant !== 4'b1000 || sel !== 2'd3) begin errors++; $display("FAIL wrap_first got g=%h s=%0d exp 8/3", grant, sel); end
    step(4'b1000);
    req = 4'b0001; #1;
    vectors++; if (grant !== 4'b0001 || sel !== 2'd0) begin errors++; $display("FAIL wrap_second got g=%h s=%0d exp 1/0", grant, sel); end
    step(4'b0001);
    // Ptr should now be 1: with entries 0 and 1 requesting, entry 1 wins.
    req = 4'b0011; #1;
    vectors++; if (grant !== 4'b0010 || sel !== 2'd1) begin errors++; $display("FAIL wrap_ptr1 got g=%h s=%0d exp 2/1", grant, sel); end
    step(4'b0010);
    req = 4'b0000; #1;
    vectors++; if (cnt !== exp_cnt) begin errors++; $display("FAIL wrap_cnt got %0d exp %0d", cnt, exp_cnt); end
  endtask

  task automatic test_cdb_claim();
    // Ptr is 2. Entry 1 ADD, entry 2 branch (warp 2), CDB claimed.
    claim = 1'b1; isbr = 4'b0100; req = 4'b0110; #1;
    vectors++; if (grant !== 4'b0100 || valid !== 1'b1 || sel !== 2'd2) begin errors++; $display("FAIL cdb_branch got g=%h v=%b s=%0d exp 4/1/2", grant, valid, sel); end
    step(4'b0100);
    vectors++; if (brp !== (BR_EN ? 8'h04 : 8'h00)) begin errors++; $display("FAIL cdb_brp got %h exp %h", brp, BR_EN ? 8'h04 : 8'h00); end
    req = 4'b0010; isbr = 4'b0000; #1;
    vectors++; if (grant !== 4'h0 || valid !== 1'b0 || sel !== 2'd0) begin errors++; $display("FAIL cdb_hold got g=%h v=%b s=%0d exp 0/0/0", grant, valid, sel); end
    step(4'b0000);
    claim = 1'b0; #1;
    vectors++; if (grant !== 4'b0010 || valid !== 1'b1 || sel !== 2'd1) begin errors++; $display("FAIL cdb_release got g=%h v=%b s=%0d exp 2/1/1", grant, valid, sel); end
    step(4'b0010);
    req = 4'b0000; brd = 1'b1; brd_w = 3'd2; #1;
    step(4'b0000);
    brd = 1'b0; #1;
    vectors++; if (brp !== 8'h00) begin errors++; $display("FAIL cdb_brdone got %h exp 00", brp); end
  endtask

  task automatic test_br_block();
    logic [3:0] eg;
    // Ptr is 2. Entry 0 branch warp 5, entry 1 ADD warp 5.
    wid = {3'd3, 3'd2, 3'd5, 3'd5}; isbr = 4'b0001; req = 4'b0011; #1;
    vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL blk_branch got %h exp 1", grant); end
    step(4'b0001);
    vectors++; if (brp !== (BR_EN ? 8'h20 : 8'h00)) begin errors++; $display("FAIL blk_brp_set got %h exp %h", brp, BR_EN ? 8'h20 : 8'h00); end
    req = 4'b0010; isbr = 4'b0000; #1;
    eg = BR_EN ? 4'b0000 : 4'b0010;
    vectors++; if (grant !== eg) begin errors++; $display("FAIL blk_wait got %h exp %h", grant, eg); end
    step(eg);
    req = req & ~eg;
    // BrDone in the same cycle still sees the registered flag.
    brd = 1'b1; brd_w = 3'd5; #1;
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL blk_same_cycle got %h exp 0", grant); end
    step(4'b0000);
    brd = 1'b0; #1;
    vectors++; if (brp !== 8'h00) begin errors++; $display("FAIL blk_brp_clr got %h exp 00", brp); end
    eg = BR_EN ? 4'b0010 : 4'b0000;
    vectors++; if (grant !== eg) begin errors++; $display("FAIL blk_release got %h exp %h", grant, eg); end
    step(eg);
    req = 4'b0000; #1;
    vectors++; if (cnt !== exp_cnt) begin errors++; $display("FAIL blk_cnt got %0d exp %0d", cnt, exp_cnt); end
  endtask

  task automatic test_br_done_mix();
    // Branch grant for warp 3 with a stray BrDone for clear warp 6.
    wid = {3'd0, 3'd0, 3'd0, 3'd3}; isbr = 4'b0001; req = 4'b0001; brd = 1'b1; brd_w = 3'd6; #1;
    vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL mix_g1 got %h exp 1", grant); end
    step(4'b0001);
    vectors++; if (brp !== (BR_EN ? 8'h08 : 8'h00)) begin errors++; $display("FAIL mix_brp1 got %h exp %h", brp, BR_EN ? 8'h08 : 8'h00); end
    // Branch grant for warp 4 while warp 3 resolves: both apply.
    wid = {3'd0, 3'd0, 3'd0, 3'd4}; brd_w = 3'd3; #1;
    vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL mix_g2 got %h exp 1", grant); end
    step(4'b0001);
    vectors++; if (brp !== (BR_EN ? 8'h10 : 8'h00)) begin errors++; $display("FAIL mix_brp2 got %h exp %h", brp, BR_EN ? 8'h10 : 8'h00); end
    req = 4'b0000; isbr = 4'b0000; brd_w = 3'd4; #1;
    step(4'b0000);
    brd = 1'b0; #1;
    vectors++; if (brp !== 8'h00) begin errors++; $display("FAIL mix_brp3 got %h exp 00", brp); end
  endtask

  task automatic test_reset_mid();
    // Ptr is 1 here; grant entry 2 to leave Ptr at 3.
    wid = WID0; req = 4'b0100; #1;
    vectors++; if (grant !== 4'b0100) begin errors++; $display("FAIL rmid_setup got %h exp 4", grant); end
    step(4'b0100);
    req = 4'b1100; rst = 1'b0; #1;
    vectors++; if (grant !== 4'h0 || valid !== 1'b0 || sel !== 2'd0) begin errors++; $display("FAIL rmid_idle got g=%h v=%b s=%0d exp 0/0/0", grant, valid, sel); end
    vectors++; if (cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt got %0d exp 0", cnt); end
    @(negedge clk);
    rst = 1'b1; #1;
    vectors++; if (grant !== 4'b0100 || sel !== 2'd2) begin errors++; $display("FAIL rmid_first got g=%h s=%0d exp 4/2", grant, sel); end
    @(posedge clk); #1;
    req = 4'b0000; #1;
    vectors++; if (cnt !== 16'd1) begin errors++; $display("FAIL rmid_cnt_after got %0d exp 1", cnt); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap_ptr();
    test_cdb_claim();
    test_br_block();
    test_br_done_mix();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
